// File: rtl/wb_rr_arbiter_wdt.sv
// wb_rr_arbiter_wdt
//   Round-robin arbiter that lets N_REQ Wishbone masters share one slave port,
//   with a per-grant stall watchdog.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rstn       : asynchronous active-low reset
//   req        : per-master CYC&STB request
//   cyc        : per-master CYC; the owner keeps the grant while its CYC is high
//   s_ack      : ACK from the shared slave
//   s_err      : ERR from the shared slave
//   gnt        : registered one-hot grant vector
//   gnt_valid  : OR of gnt
//   gnt_id     : index of the granted master, 0 when nothing is granted
//   wdt_err    : single-cycle watchdog ERR toward the granted master
//   wdt_count  : saturating count of watchdog events since reset
module wb_rr_arbiter_wdt #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic [N_REQ-1:0]                             req,
  input  logic [N_REQ-1:0]                             cyc,
  input  logic                                         s_ack,
  input  logic                                         s_err,
  output logic [N_REQ-1:0]                             gnt,
  output logic                                         gnt_valid,
  output logic [((N_REQ > 2) ? $clog2(N_REQ) : 1)-1:0] gnt_id,
  output logic                                         wdt_err,
  output logic [7:0]                                   wdt_count
);

  localparam int unsigned IDW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t            state;
  logic [IDW-1:0]    last_id;
  logic [IDW-1:0]    win_id;
  logic              win_found;
  logic [CW-1:0]     wd_cnt;
  logic              wd_cond;
  int unsigned       scan_idx;

  // Rotating priority: scan upward from the master after the last owner.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      scan_idx = (int'(last_id) + i) % N_REQ;
      if (!win_found && req[scan_idx[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[IDW-1:0];
      end
    end
  end

  // The cycle carrying wdt_err does not count, so a permanent stall yields one
  // error every TIMEOUT_CYCLES+1 cycles, the same spacing as from grant entry.
  assign wd_cond = (state == GRANT) && req[gnt_id] && !s_ack && !s_err && !wdt_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      last_id   <= IDW'(N_REQ - 1);
      wd_cnt    <= '0;
      wdt_err   <= 1'b0;
      wdt_count <= '0;
    end else begin
      wdt_err <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (win_found) begin
            state     <= GRANT;
            gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
            gnt_valid <= 1'b1;
            gnt_id    <= win_id;
            last_id   <= win_id;
          end
        end
        GRANT: begin
          if (!cyc[gnt_id]) begin
            state     <= RELEASE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
          end
          if (TIMEOUT_CYCLES == 0 || !wd_cond) begin
            wd_cnt <= '0;
          end else if (wd_cnt == CW'(LIM)) begin
            wd_cnt  <= '0;
            wdt_err <= 1'b1;
            if (wdt_count != 8'hFF) wdt_count <= wdt_count + 8'd1;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        RELEASE: begin
          state  <= IDLE;
          wd_cnt <= '0;
        end
        default: begin
          state  <= IDLE;
          wd_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter_wdt.sv
module tb_wb_rr_arbiter_wdt;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req, cyc;
  logic       s_ack, s_err;

  logic [3:0] gnt, gnt0;
  logic       gnt_valid, gv0;
  logic [1:0] gnt_id, id0;
  logic       wdt_err, we0;
  logic [7:0] wdt_count, wc0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter_wdt #(.N_REQ(4), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn), .req(req), .cyc(cyc), .s_ack(s_ack), .s_err(s_err),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
    .wdt_err(wdt_err), .wdt_count(wdt_count)
  );

  // Same stimulus, watchdog disabled.
  wb_rr_arbiter_wdt #(.N_REQ(4), .TIMEOUT_CYCLES(0)) dut_nowd (
    .clk(clk), .rstn(rstn), .req(req), .cyc(cyc), .s_ack(s_ack), .s_err(s_err),
    .gnt(gnt0), .gnt_valid(gv0), .gnt_id(id0),
    .wdt_err(we0), .wdt_count(wc0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; req = '0; cyc = '0; s_ack = 1'b0; s_err = 1'b0;
    #3;
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_grant: got gnt=%b valid=%b id=%0d required 0000/0/0", gnt, gnt_valid, gnt_id);
    end
    checks++;
    if (wdt_err !== 1'b0 || wdt_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_wdt: got err=%b count=%0d required 0/0", wdt_err, wdt_count);
    end
    tick;
    rstn = 1'b1;
    tick;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL idle_no_req: got gnt=%b required 0000", gnt);
    end
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp;
    s_ack = 1'b1;
    req = 4'hF; cyc = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << order[k];
      tick;
      checks++;
      if (gnt !== exp || gnt_valid !== 1'b1 || gnt_id !== 2'(order[k])) begin
        errors++;
        $display("FAIL rr_grant k=%0d: got gnt=%b valid=%b id=%0d required %b/1/%0d",
                 k, gnt, gnt_valid, gnt_id, exp, order[k]);
      end
      tick;
      checks++;
      if (gnt !== exp) begin
        errors++;
        $display("FAIL rr_hold k=%0d: got gnt=%b required %b", k, gnt, exp);
      end
      if (k == 4) break;
      req[order[k]] = 1'b0; cyc[order[k]] = 1'b0;
      tick;
      checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
        errors++;
        $display("FAIL rr_release k=%0d: got gnt=%b valid=%b id=%0d required 0000/0/0",
                 k, gnt, gnt_valid, gnt_id);
      end
      req[order[k]] = 1'b1; cyc[order[k]] = 1'b1;
      tick;
      checks++;
      if (gnt !== 4'b0000) begin
        errors++;
        $display("FAIL rr_gap k=%0d: got gnt=%b required 0000", k, gnt);
      end
    end
    req = '0; cyc = '0;
    tick; tick;
  endtask

  task automatic test_locked;
    s_ack = 1'b1;
    req = 4'b0100; cyc = 4'b0100;
    tick;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL lock_grant: got gnt=%b required 0100", gnt);
    end
    req[0] = 1'b1; cyc[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req[2] = ~req[2];
      tick;
      checks++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
        errors++;
        $display("FAIL lock_hold i=%0d: got gnt=%b id=%0d required 0100/2", i, gnt, gnt_id);
      end
    end
    req[2] = 1'b0; cyc[2] = 1'b0;
    tick;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL lock_release: got gnt=%b required 0000", gnt);
    end
    tick;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL lock_gap: got gnt=%b required 0000", gnt);
    end
    tick;
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL lock_next: got gnt=%b id=%0d required 0001/0", gnt, gnt_id);
    end
    req = '0; cyc = '0;
    tick; tick;
  endtask

  task automatic test_ack_clears;
    s_ack = 1'b0;
    req = 4'b0010; cyc = 4'b0010;
    tick;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL ack_grant: got gnt=%b required 0010", gnt);
    end
    for (int t = 1; t <= 7; t++) begin
      s_ack = (t == 4);
      tick;
      checks++;
      if (wdt_err !== 1'b0) begin
        errors++;
        $display("FAIL ack_no_wdt t=%0d: got wdt_err=%b required 0", t, wdt_err);
      end
    end
    checks++;
    if (wdt_count !== 8'd0 || gnt !== 4'b0010) begin
      errors++;
      $display("FAIL ack_count: got count=%0d gnt=%b required 0/0010", wdt_count, gnt);
    end
    s_ack = 1'b0; req = '0; cyc = '0;
    tick; tick;
  endtask

  task automatic test_watchdog_saturate;
    logic       exp_err;
    logic [7:0] exp_cnt;
    s_ack = 1'b0;
    req = 4'b0010; cyc = 4'b0010;
    tick;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL wdt_grant: got gnt=%b required 0010", gnt);
    end
    for (int t = 1; t <= 1560; t++) begin
      tick;
      exp_err = ((t % 5) == 4);
      exp_cnt = ((t + 1) / 5 > 255) ? 8'd255 : 8'((t + 1) / 5);
      checks++;
      if (wdt_err !== exp_err || wdt_count !== exp_cnt) begin
        errors++;
        $display("FAIL wdt_pulse t=%0d: got err=%b count=%0d required %b/%0d",
                 t, wdt_err, wdt_count, exp_err, exp_cnt);
      end
      checks++;
      if (gnt !== 4'b0010 || we0 !== 1'b0) begin
        errors++;
        $display("FAIL wdt_side t=%0d: got gnt=%b nowd_err=%b required 0010/0", t, gnt, we0);
      end
    end
    checks++;
    if (wdt_count !== 8'd255 || wc0 !== 8'd0) begin
      errors++;
      $display("FAIL wdt_saturate: got count=%0d nowd_count=%0d required 255/0", wdt_count, wc0);
    end
    req = '0; cyc = '0;
    tick; tick;
  endtask

  task automatic test_reset_mid_grant;
    req = 4'b1000; cyc = 4'b1000;
    tick;
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL rst_pre_grant: got gnt=%b required 1000", gnt);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || wdt_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_async: got gnt=%b valid=%b id=%0d count=%0d required 0000/0/0/0",
               gnt, gnt_valid, gnt_id, wdt_count);
    end
    req = 4'b1001; cyc = 4'b1001;
    tick;
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL rst_held: got gnt=%b required 0000", gnt);
    end
    #2 rstn = 1'b1;
    tick;
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_first_grant: got gnt=%b id=%0d required 0001/0", gnt, gnt_id);
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_locked;
    test_ack_clears;
    test_watchdog_saturate;
    test_reset_mid_grant;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_rr_arbiter_wdt.md
WB_RR_ARBITER_WDT -- requirements
Module: wb_rr_arbiter_wdt

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of Wishbone masters sharing one slave port (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256: stall cycles before a watchdog error (0 = watchdog disabled).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, N_REQ: per-master CYC&STB request.
REQ-006 SHALL have port cyc, input, N_REQ: per-master CYC (bus-cycle hold).
REQ-007 SHALL have port s_ack, input, 1: ACK from the shared slave.
REQ-008 SHALL have port s_err, input, 1: ERR from the shared slave.
REQ-009 SHALL have port gnt, output, N_REQ: one-hot grant vector, registered.
REQ-010 SHALL have port gnt_valid, output, 1: OR of gnt.
REQ-011 SHALL have port gnt_id, output, max(1,$clog2(N_REQ)): index of granted master; 0 when gnt_valid=0.
REQ-012 SHALL have port wdt_err, output, 1: single-cycle watchdog ERR toward the granted master.
REQ-013 SHALL have port wdt_count, output, 8: saturating count of watchdog events since reset.

Function
REQ-014 SHALL implement states IDLE, GRANT, RELEASE.
REQ-015 IDLE: if any req bit set, SHALL select winner and enter GRANT; gnt/gnt_id/gnt_valid update on the same edge (1-cycle latency req->gnt).
REQ-016 Winner SHALL be first set req bit scanning upward from (last_id+1) mod N_REQ with wrap; last_id updates to winner on grant.
REQ-017 GRANT: grant SHALL be held while cyc[gnt_id]=1, regardless of req changes on any master, including the owner dropping STB (locked cycle).
REQ-018 GRANT: cyc[gnt_id]=0 SHALL move to RELEASE, clearing gnt, gnt_valid, gnt_id on that edge.
REQ-019 RELEASE SHALL last exactly one cycle (bus turnaround, no grant), then enter IDLE; arbitration resumes in IDLE, so minimum owner-to-owner gap is 2 cycles without grant.
REQ-020 Watchdog counter SHALL count cycles in GRANT with req[gnt_id]=1 and s_ack=0 and s_err=0; it SHALL clear on s_ack, s_err, entry to GRANT, or req[gnt_id]=0.
REQ-021 When counter reaches TIMEOUT_CYCLES-1 while the count condition holds, next cycle SHALL assert wdt_err=1 for exactly one cycle, clear the counter, and increment wdt_count (saturates at 255).
REQ-022 wdt_err SHALL NOT assert in the same cycle as s_ack or s_err; slave response wins and clears the counter.
REQ-023 wdt_err SHALL NOT alter the grant; release still requires cyc[gnt_id]=0.
REQ-024 TIMEOUT_CYCLES=0 SHALL hold counter at 0 and wdt_err at 0 permanently.
REQ-025 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), min 1; no overflow possible.
REQ-026 gnt SHALL never have more than one bit set; gnt_id SHALL always equal the index of the set bit.

Reset
REQ-027 rstn=0 SHALL asynchronously force: state IDLE, gnt=0, gnt_valid=0, gnt_id=0, wdt_err=0, wdt_count=0, counter=0, last_id=N_REQ-1 (master 0 has top priority first).
REQ-028 Reset asserted mid-GRANT SHALL drop grant immediately (no clock needed); first grant after rstn rises is evaluated on the first clock edge with rstn=1.

Verification
REQ-029 After reset, req=4'b1111, cyc follows req -> grant order 0,1,2,3,0 with each owner holding until its cyc drops and 2 no-grant cycles between owners.
REQ-030 Owner 2 holds cyc=1, req[2] toggles, req[0]=1 throughout -> gnt stays 4'b0100 until cyc[2]=0; then gnt=4'b0001 two cycles later.
REQ-031 TIMEOUT_CYCLES=4, owner 1 req=1, s_ack=0 -> wdt_err pulses 1 cycle on the 5th cycle after grant, wdt_count=1, gnt unchanged; repeats every 5 cycles.
REQ-032 TIMEOUT_CYCLES=4, s_ack on 4th stall cycle -> no wdt_err, counter cleared, wdt_count stays 0.
REQ-033 rstn pulsed low mid-grant with gnt=4'b1000 -> gnt=0 asynchronously; after release with req=4'b1001 -> master 0 granted first.
REQ-034 Force 300 watchdog events -> wdt_count reads 255 and holds.
